// File: rtl/bf_loader_pkg.sv
// Shared encodings for the BF program loader: loader states and the control bytes
// that end a program upload or restart loading after a halt.
package bf_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } loader_state_t;

    localparam logic [7:0] TERM_BYTE   = 8'h00;
    localparam logic [7:0] RELOAD_BYTE = 8'h1B;

    // The loader owns the RAM ports and holds the core in reset in these states.
    function automatic logic loader_owns_rams(input loader_state_t s);
        return (s == ST_LOAD) || (s == ST_CLEAR);
    endfunction

endpackage

// File: rtl/bf_rx_edge.sv
// Turns the UART byte-valid level into a single-cycle strobe on its rising edge,
// so a level held for many cycles is accepted only once.
module bf_rx_edge (
    input  logic clk,
    input  logic reset,
    input  logic rx_level,
    output logic strobe
);

    logic rx_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_prev <= 1'b0;
        end else begin
            rx_prev <= rx_level;
        end
    end

    assign strobe = rx_level & ~rx_prev;

endmodule

// File: rtl/bf_program_loader.sv
// Loads a BF program from UART into code RAM, zeroes the data array, then runs the
// core until it reports done; an ESC byte while halted starts a fresh upload.
module bf_program_loader
    import bf_loader_pkg::*;
#(
    parameter int CODE_WIDTH  = 5,
    parameter int ARRAY_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   receivingChar,
    input  logic [7:0]             receivedChar,
    input  logic                   core_done,
    input  logic [CODE_WIDTH-1:0]  core_addr_code,
    output logic [CODE_WIDTH-1:0]  code_addr,
    output logic [7:0]             code_data,
    output logic                   code_write,
    output logic                   array_sel,
    output logic [ARRAY_WIDTH-1:0] array_addr,
    output logic [7:0]             array_data,
    output logic                   array_write,
    output logic                   core_reset,
    output logic                   core_rx,
    output logic [1:0]             state,
    output logic                   overflow
);

    localparam logic [CODE_WIDTH-1:0]  CODE_LAST  = '1;
    localparam logic [CODE_WIDTH-1:0]  CODE_STEP  = CODE_WIDTH'(1);
    localparam logic [ARRAY_WIDTH-1:0] ARRAY_LAST = '1;
    localparam logic [ARRAY_WIDTH-1:0] ARRAY_STEP = ARRAY_WIDTH'(1);

    loader_state_t          cur_state;
    logic [CODE_WIDTH-1:0]  load_addr;
    logic [CODE_WIDTH-1:0]  wr_addr;
    logic [ARRAY_WIDTH-1:0] clear_addr;
    logic                   strobe;

    bf_rx_edge u_rx_edge (
        .clk      (clk),
        .reset    (reset),
        .rx_level (receivingChar),
        .strobe   (strobe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= ST_LOAD;
            load_addr  <= '0;
            wr_addr    <= '0;
            clear_addr <= '0;
            code_data  <= 8'h00;
            code_write <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            code_write <= 1'b0;
            case (cur_state)
                ST_LOAD: begin
                    if (strobe) begin
                        code_write <= 1'b1;
                        wr_addr    <= load_addr;
                        if (receivedChar == TERM_BYTE) begin
                            code_data <= TERM_BYTE;
                            cur_state <= ST_CLEAR;
                        end else if (load_addr == CODE_LAST) begin
                            // Out of code space: force a terminator into the last slot.
                            code_data <= TERM_BYTE;
                            overflow  <= 1'b1;
                            cur_state <= ST_CLEAR;
                        end else begin
                            code_data <= receivedChar;
                            load_addr <= load_addr + CODE_STEP;
                        end
                    end
                end
                ST_CLEAR: begin
                    clear_addr <= clear_addr + ARRAY_STEP;
                    if (clear_addr == ARRAY_LAST) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        cur_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (strobe && receivedChar == RELOAD_BYTE) begin
                        cur_state <= ST_LOAD;
                        load_addr <= '0;
                        overflow  <= 1'b0;
                    end
                end
                default: cur_state <= ST_LOAD;
            endcase
        end
    end

    // Port ownership and core reset decode straight from the state register.
    assign state       = cur_state;
    assign array_sel   = loader_owns_rams(cur_state);
    assign core_reset  = ~loader_owns_rams(cur_state);
    assign array_write = (cur_state == ST_CLEAR);
    assign array_addr  = clear_addr;
    assign array_data  = 8'h00;
    assign core_rx     = (cur_state == ST_RUN) & receivingChar;
    assign code_addr   = loader_owns_rams(cur_state) ? wr_addr : core_addr_code;

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader: upload, clear sweep, run/halt/reload,
// overflow, held-level single write and reset during clear.
module tb_bf_program_loader;

    localparam int CW = 5;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          receivingChar;
    logic [7:0]    receivedChar;
    logic          core_done;
    logic [CW-1:0] core_addr_code;
    logic [CW-1:0] code_addr;
    logic [7:0]    code_data;
    logic          code_write;
    logic          array_sel;
    logic [AW-1:0] array_addr;
    logic [7:0]    array_data;
    logic          array_write;
    logic          core_reset;
    logic          core_rx;
    logic [1:0]    state;
    logic          overflow;

    bf_program_loader #(.CODE_WIDTH(CW), .ARRAY_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .receivingChar  (receivingChar),
        .receivedChar   (receivedChar),
        .core_done      (core_done),
        .core_addr_code (core_addr_code),
        .code_addr      (code_addr),
        .code_data      (code_data),
        .code_write     (code_write),
        .array_sel      (array_sel),
        .array_addr     (array_addr),
        .array_data     (array_data),
        .array_write    (array_write),
        .core_reset     (core_reset),
        .core_rx        (core_rx),
        .state          (state),
        .overflow       (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks;
    int failures;
    int write_count;
    logic [12:0] exp_q[$];
    logic [7:0]  code_ram[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every code RAM write must match the next expected {addr, data}.
    always @(posedge clk) begin
        if (reset && code_write === 1'b1) begin
            logic [12:0] e;
            write_count++;
            code_ram[code_addr] = code_data;
            if (exp_q.size() == 0) begin
                check("unexpected_code_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("code_write_addr", 32'(code_addr), 32'(e[12:8]));
                check("code_write_data", 32'(code_data), 32'(e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        receivedChar  = b;
        receivingChar = 1'b1;
        repeat (hold) @(negedge clk);
        receivingChar = 1'b0;
    endtask

    // Walks the clear phase from its first cycle, checking the sweep, returns its length.
    task automatic run_clear(output int n);
        n = 0;
        while (state == 2'd1 && n < 200) begin
            check("clear_array_addr", 32'(array_addr), 32'(n[AW-1:0]));
            check("clear_array_write", 32'(array_write), 32'd1);
            check("clear_array_sel", 32'(array_sel), 32'd1);
            check("clear_core_reset", 32'(core_reset), 32'd0);
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0]    data;
        logic [CW-1:0] exp_addr;
        logic [7:0]    exp_wdata;
        logic [1:0]    exp_state;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[4];
    int   n;
    int   wc0;
    logic rc;

    initial begin
        checks = 0; failures = 0; write_count = 0;
        vecs[0] = '{8'h2B, 5'd0, 8'h2B, 2'd0, 1'b0};
        vecs[1] = '{8'h2B, 5'd1, 8'h2B, 2'd0, 1'b0};
        vecs[2] = '{8'h2E, 5'd2, 8'h2E, 2'd0, 1'b0};
        vecs[3] = '{8'h00, 5'd3, 8'h00, 2'd1, 1'b0};

        receivingChar = 1'b0; receivedChar = 8'h00;
        core_done = 1'b0; core_addr_code = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_array_sel", 32'(array_sel), 32'd1);
        check("rst_core_reset", 32'(core_reset), 32'd0);
        check("rst_code_write", 32'(code_write), 32'd0);
        check("rst_array_write", 32'(array_write), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ---- table-driven upload ----
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_wdata});
            send_byte(vecs[i].data, 1);
            check("vec_code_write", 32'(code_write), 32'd1);
            check("vec_code_addr", 32'(code_addr), 32'(vecs[i].exp_addr));
            check("vec_code_data", 32'(code_data), 32'(vecs[i].exp_wdata));
            check("vec_state", 32'(state), 32'(vecs[i].exp_state));
            check("vec_overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
        end
        run_clear(n);
        check("clear_len", 32'(n), 32'd32);
        check("run_state", 32'(state), 32'd2);
        check("run_core_reset", 32'(core_reset), 32'd1);
        check("run_array_sel", 32'(array_sel), 32'd0);
        check("run_array_write", 32'(array_write), 32'd0);
        check("ram0", 32'(code_ram[0]), 32'h2B);
        check("ram1", 32'(code_ram[1]), 32'h2B);
        check("ram2", 32'(code_ram[2]), 32'h2E);
        check("ram3", 32'(code_ram[3]), 32'h00);

        // ---- RUN: code_addr follows core, core_rx mirrors receivingChar ----
        for (int i = 0; i < 32; i++) begin
            core_addr_code = i[CW-1:0];
            rc = 1'($urandom_range(0, 1));
            receivingChar = rc;
            #1;
            check("run_code_addr", 32'(code_addr), 32'(i));
            check("run_code_write", 32'(code_write), 32'd0);
            check("run_core_rx", 32'(core_rx), 32'(rc));
            @(negedge clk);
        end
        receivingChar = 1'b0;
        @(negedge clk);

        // ---- overflow: 32 bytes into a 32-entry code RAM ----
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back({i[CW-1:0], (i == 31) ? 8'h00 : 8'h2B});
            send_byte(8'h2B, 1);
            check("ovf_state", 32'(state), (i == 31) ? 32'd1 : 32'd0);
            check("ovf_flag", 32'(overflow), (i == 31) ? 32'd1 : 32'd0);
        end
        check("ovf_ram30", 32'(code_ram[30]), 32'h2B);
        check("ovf_ram31", 32'(code_ram[31]), 32'h00);
        run_clear(n);
        check("ovf_clear_len", 32'(n), 32'd32);

        // ---- RUN -> HALT -> ignore -> reload ----
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("halt_state", 32'(state), 32'd3);
        check("halt_core_reset", 32'(core_reset), 32'd1);
        check("halt_overflow_kept", 32'(overflow), 32'd1);
        send_byte(8'h20, 1);
        @(negedge clk);
        check("halt_ignore_state", 32'(state), 32'd3);
        send_byte(8'h1B, 1);
        check("reload_state", 32'(state), 32'd0);
        check("reload_core_reset", 32'(core_reset), 32'd0);
        check("reload_overflow", 32'(overflow), 32'd0);
        check("reload_core_rx", 32'(core_rx), 32'd0);

        // ---- level held 50 cycles yields one write at address 0 ----
        wc0 = write_count;
        exp_q.push_back({5'd0, 8'h2B});
        send_byte(8'h2B, 50);
        check("hold_core_rx", 32'(core_rx), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_write_count", 32'(write_count - wc0), 32'd1);
        check("hold_state", 32'(state), 32'd0);

        // ---- reset in the middle of CLEAR ----
        exp_q.push_back({5'd1, 8'h00});
        send_byte(8'h00, 1);
        n = 0;
        while (array_addr != 5'd10 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("clear_reach_10", 32'(n < 100), 32'd1);
        check("mid_clear_state", 32'(state), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_array_write", 32'(array_write), 32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd0);
        check("abort_array_sel", 32'(array_sel), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        wc0 = write_count;
        repeat (10) @(negedge clk);
        check("abort_no_writes", 32'(write_count - wc0), 32'd0);
        check("abort_still_load", 32'(state), 32'd0);
        check("abort_array_idle", 32'(array_write), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
